// File: rtl/sdram_to_udp_reader.sv
// Reads one RGB frame from the frame_read_write read port and streams it as R,G,B byte UDP payload packets.
// Optional `define FRAME_HEADER_EN prefixes each packet with {A5, frame_id, pkt_idx[15:8], pkt_idx[7:0]}.
module sdram_to_udp_reader #(
  parameter int PIXEL_COUNT = 307200,
  parameter int PKT_PIXELS  = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  output logic        busy,
  output logic        frame_done,
  output logic        read_req,
  input  logic        read_req_ack,
  output logic        read_en,
  input  logic [31:0] read_data,
  output logic        pkt_req,
  output logic [15:0] pkt_len,
  input  logic        pkt_ack,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        tx_last
);
  typedef enum logic [2:0] {IDLE, REQ, PKT_OPEN, STREAM, DONE} state_t;

`ifdef FRAME_HEADER_EN
  localparam int HDR_BYTES = 4;
`else
  localparam int HDR_BYTES = 0;
`endif
  localparam logic [18:0] PIX_TOTAL = 19'(PIXEL_COUNT);
  localparam logic [18:0] PKT_PIX19 = 19'(PKT_PIXELS);
  localparam logic [15:0] PKT_PIX16 = 16'(PKT_PIXELS);

  state_t      state, state_nxt;
  logic [18:0] pix_cnt;
  logic [15:0] pkt_idx;
  logic [15:0] rd_left;
  logic [15:0] tx_left;
  logic [23:0] word_q;
  logic        word_vld;
  logic [1:0]  byte_idx;
  logic        rd_inflight;
  logic [18:0] pix_remain;
  logic [15:0] pkt_pix;
  logic        tx_free, load_hdr, load_pix, pkt_end;
  logic        hdr_phase;
  logic [7:0]  hdr_byte;
  logic [7:0]  pix_byte;
  logic        unused_bits;

`ifdef FRAME_HEADER_EN
  logic [2:0]  hdr_idx;
  logic [7:0]  frame_id;

  assign hdr_phase = (hdr_idx != 3'd4);
  always_comb begin
    hdr_byte = 8'hA5;
    case (hdr_idx[1:0])
      2'd1:    hdr_byte = frame_id;
      2'd2:    hdr_byte = pkt_idx[15:8];
      2'd3:    hdr_byte = pkt_idx[7:0];
      default: hdr_byte = 8'hA5;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_idx  <= 3'd0;
      frame_id <= 8'd0;
    end else begin
      if (state == PKT_OPEN && pkt_ack) hdr_idx <= 3'd0;
      else if (load_hdr)                hdr_idx <= hdr_idx + 3'd1;
      if (state == DONE) frame_id <= frame_id + 8'd1;
    end
  end
`else
  assign hdr_phase = 1'b0;
  assign hdr_byte  = 8'h00;
`endif

  // The top byte of each SDRAM word is padding; pkt_idx only leaves the block inside headers.
  assign unused_bits = ^{read_data[31:24], pkt_idx};

  assign tx_free  = !tx_valid || tx_ready;
  assign load_hdr = (state == STREAM) && hdr_phase && tx_free;
  assign load_pix = (state == STREAM) && !hdr_phase && word_vld && tx_free;
  assign pkt_end  = tx_valid && tx_ready && tx_last;

  always_comb begin
    pix_remain = PIX_TOTAL - pix_cnt;
    pkt_pix    = (pix_remain < PKT_PIX19) ? pix_remain[15:0] : PKT_PIX16;
    case (byte_idx)
      2'd0:    pix_byte = word_q[23:16];
      2'd1:    pix_byte = word_q[15:8];
      default: pix_byte = word_q[7:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    read_req   = (state == REQ);
    pkt_req    = (state == PKT_OPEN);
    frame_done = (state == DONE);
    pkt_len    = 16'd0;
    // One word in flight at most; a new read overlaps the last byte of the held word.
    read_en    = (state == STREAM) && !hdr_phase && !rd_inflight && (rd_left != 16'd0) &&
                 (!word_vld || (load_pix && byte_idx == 2'd2));
    case (state)
      IDLE:     if (frame_start) state_nxt = REQ;
      REQ:      if (read_req_ack) state_nxt = PKT_OPEN;
      PKT_OPEN: begin
        pkt_len = 16'(3 * 32'(pkt_pix) + HDR_BYTES);
        if (pkt_ack) state_nxt = STREAM;
      end
      STREAM:   if (pkt_end) state_nxt = (pix_cnt < PIX_TOTAL) ? PKT_OPEN : DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt     <= 19'd0;
      pkt_idx     <= 16'd0;
      rd_left     <= 16'd0;
      tx_left     <= 16'd0;
      word_q      <= 24'd0;
      word_vld    <= 1'b0;
      byte_idx    <= 2'd0;
      rd_inflight <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= 8'd0;
      tx_last     <= 1'b0;
    end else begin
      if (state == IDLE && frame_start) begin
        pix_cnt <= 19'd0;
        pkt_idx <= 16'd0;
      end
      if (state == PKT_OPEN && pkt_ack) begin
        rd_left <= pkt_pix;
        tx_left <= pkt_pix;
      end
      if (read_en) begin
        rd_left <= rd_left - 16'd1;
        pix_cnt <= pix_cnt + 19'd1;
      end
      rd_inflight <= read_en;

      if (load_pix) begin
        byte_idx <= (byte_idx == 2'd2) ? 2'd0 : byte_idx + 2'd1;
        if (byte_idx == 2'd2) begin
          word_vld <= 1'b0;
          tx_left  <= tx_left - 16'd1;
        end
      end
      if (rd_inflight) begin
        word_q   <= read_data[23:0];
        word_vld <= 1'b1;
        byte_idx <= 2'd0;
      end

      // Output register only changes on an empty slot or a completed handshake.
      if (load_hdr) begin
        tx_valid <= 1'b1;
        tx_data  <= hdr_byte;
        tx_last  <= 1'b0;
      end else if (load_pix) begin
        tx_valid <= 1'b1;
        tx_data  <= pix_byte;
        tx_last  <= (byte_idx == 2'd2) && (tx_left == 16'd1);
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
        tx_last  <= 1'b0;
      end

      if (pkt_end) pkt_idx <= pkt_idx + 16'd1;
    end
  end
endmodule

// File: tb/tb_sdram_to_udp_reader.sv
// Directed bench for sdram_to_udp_reader on a 6-pixel frame split into 4+2 pixel packets.
// A queue-based packet model is compared against every accepted byte and every packet request.
module tb_sdram_to_udp_reader;
  localparam int PIX  = 6;
  localparam int PKTP = 4;
`ifdef FRAME_HEADER_EN
  localparam int HDR = 4;
`else
  localparam int HDR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, frame_start, busy, frame_done;
  logic        read_req, read_req_ack, read_en;
  logic [31:0] read_data;
  logic        pkt_req, pkt_ack;
  logic [15:0] pkt_len;
  logic        tx_valid, tx_ready, tx_last;
  logic [7:0]  tx_data;

  sdram_to_udp_reader #(.PIXEL_COUNT(PIX), .PKT_PIXELS(PKTP)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
    .read_req(read_req), .read_req_ack(read_req_ack), .read_en(read_en), .read_data(read_data),
    .pkt_req(pkt_req), .pkt_len(pkt_len), .pkt_ack(pkt_ack),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx_last(tx_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  int         len_q[$];
  int fid = 0, ack_delay = 0;
  bit rand_ready = 1'b0;
  int rd_ptr = 0, rd_cnt = 0, done_cnt = 0, rreq_cyc = 0, cap_n = 0, len_n = 0;
  logic [7:0] cap[0:63];
  int         cap_len[0:7];
  bit         rd_pend = 1'b0, req_seen = 1'b0, stall_prev = 1'b0;
  logic [8:0] prev_out = 9'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pix_word(input int k);
    logic [7:0] b;
    b = 8'(16 * k);
    return {8'hDD, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction

  // Expected payload: optional header, then R,G,B of each pixel, tx_last on the final B of a packet.
  task automatic load_model();
    int base, p, n;
    logic [31:0] w;
    exp_q.delete();
    len_q.delete();
    base = 0;
    p = 0;
    while (base < PIX) begin
      n = (PIX - base < PKTP) ? PIX - base : PKTP;
      len_q.push_back(3 * n + HDR);
      if (HDR != 0) begin
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, 8'(fid)});
        exp_q.push_back({1'b0, 8'(p >> 8)});
        exp_q.push_back({1'b0, 8'(p)});
      end
      for (int i = 0; i < n; i++) begin
        w = pix_word(base + i);
        exp_q.push_back({1'b0, w[23:16]});
        exp_q.push_back({1'b0, w[15:8]});
        exp_q.push_back({i == n - 1, w[7:0]});
      end
      base += n;
      p++;
    end
  endtask

  // Compare process: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (reset) begin
      rd_pend = 1'b0;
      req_seen = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_hold_valid", 32'(tx_valid), 32'd1);
        chk("stall_hold_data", 32'({tx_last, tx_data}), 32'(prev_out));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte", tx_data);
        end else begin
          chk("tx_byte", 32'({tx_last, tx_data}), 32'(exp_q.pop_front()));
        end
        if (cap_n < 64) cap[cap_n] = tx_data;
        cap_n++;
      end
      stall_prev = tx_valid && !tx_ready;
      prev_out = {tx_last, tx_data};
      rd_pend = read_en;
      if (read_en) rd_cnt++;
      if (read_req) begin
        rreq_cyc++;
        chk("quiet_before_ack", 32'({pkt_req, read_en, tx_valid}), 32'd0);
      end
      req_seen = pkt_req && !pkt_ack;
      if (req_seen) begin
        if (len_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pkt_req: got len %0d, expected no packet", pkt_len);
        end else begin
          chk("pkt_len", 32'(pkt_len), 32'(len_q.pop_front()));
        end
        if (len_n < 8) cap_len[len_n] = int'(pkt_len);
        len_n++;
      end
      if (frame_done) begin
        done_cnt++;
        chk("bytes_done_before_frame_done", 32'(exp_q.size()), 32'd0);
        chk("busy_with_frame_done", 32'(busy), 32'd1);
      end
    end
  end

  // Environment: read FIFO returns the next word a cycle after read_en; UDP stack acks each request.
  initial begin
    read_data = 32'd0;
    pkt_ack = 1'b0;
    read_req_ack = 1'b0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rd_pend) begin
        read_data = pix_word(rd_ptr);
        rd_ptr++;
      end
      pkt_ack = req_seen;
      read_req_ack = read_req && (rreq_cyc >= ack_delay);
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  task automatic prep(input int delay, input bit rnd);
    ack_delay = delay;
    rand_ready = rnd;
    load_model();
    rd_ptr = 0;
    rd_cnt = 0;
    done_cnt = 0;
    rreq_cyc = 0;
    cap_n = 0;
    len_n = 0;
  endtask

  task automatic run_frame(input int delay, input bit rnd, input bit glitch);
    int cyc;
    prep(delay, rnd);
    pulse_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (glitch && (cyc == 10 || frame_done)) begin
        frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
      end
    end
    if (done_cnt == 0) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got no frame_done, expected one within 3000 cycles");
    end
    repeat (10) @(negedge clk);
    chk("frame_done_count", 32'(done_cnt), 32'd1);
    chk("read_en_count", 32'(rd_cnt), 32'(PIX));
    chk("bytes_left", 32'(exp_q.size()), 32'd0);
    chk("idle_after_frame", 32'(busy), 32'd0);
    fid = (fid + 1) % 256;
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({busy, frame_done, read_req, read_en, pkt_req, tx_valid, tx_last}), 32'd0);
    chk("reset_data", 32'({pkt_len, tx_data}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Frame 1: full-rate sink, immediate ack.
    run_frame(0, 1'b0, 1'b0);
`ifdef FRAME_HEADER_EN
    chk("pin_len0", 32'(cap_len[0]), 32'd16);
    chk("pin_len1", 32'(cap_len[1]), 32'd10);
    chk("pin_hdr0", 32'({cap[0], cap[1], cap[2], cap[3]}), 32'hA5000000);
    chk("pin_hdr1", 32'({cap[16], cap[17], cap[18], cap[19]}), 32'hA5000001);
    chk("pin_first_r", 32'(cap[4]), 32'h01);
`else
    chk("pin_len0", 32'(cap_len[0]), 32'd12);
    chk("pin_len1", 32'(cap_len[1]), 32'd6);
    chk("pin_first_r", 32'(cap[0]), 32'h01);
    chk("pin_second_r", 32'(cap[3]), 32'h11);
    chk("pin_last_b", 32'(cap[17]), 32'h53);
`endif

    // Frame 2: random backpressure, same byte stream expected.
    run_frame(0, 1'b1, 1'b0);
`ifdef FRAME_HEADER_EN
    chk("pin_frame_id2", 32'({cap[0], cap[1]}), 32'hA501);
`endif

    // Frame 3: read_req_ack held off for 20 cycles.
    run_frame(20, 1'b0, 1'b0);
    chk("read_req_held", 32'(rreq_cyc >= 20), 32'd1);

    // Frame 4: frame_start while busy and in the frame_done cycle.
    run_frame(0, 1'b1, 1'b1);

    // Abort mid-stream with reset, then a clean frame.
    prep(0, 1'b0);
    pulse_start();
    cyc = 0;
    while (cap_n < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_stream", 32'(cap_n >= 4), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_outputs", 32'({busy, frame_done, read_req, read_en, pkt_req, tx_valid, tx_last}), 32'd0);
    chk("abort_data", 32'({pkt_len, tx_data}), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    fid = 0;
    run_frame(0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
